// File: rtl/rtc_read_ctrl.sv
// Sweeps the RTC's nine BCD registers into a shadow bank and commits the whole
// bank to the display digits on a vsync falling edge, so the time never tears.
module rtc_read_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       IRQ,
    input  logic       vsync,
    input  logic       rtc_ack,
    input  logic [7:0] rtc_data,
    output logic       rtc_req,
    output logic [7:0] rtc_addr,
    output logic       busy,
    output logic       err,
    output logic [3:0] digUS,
    output logic [3:0] digDS,
    output logic [3:0] digUM,
    output logic [3:0] digDM,
    output logic [3:0] digUH,
    output logic [3:0] digDH,
    output logic [3:0] digUD,
    output logic [3:0] digDD,
    output logic [3:0] digUME,
    output logic [3:0] digDME,
    output logic [3:0] digUA,
    output logic [3:0] digDA,
    output logic [3:0] digUSC,
    output logic [3:0] digDSC,
    output logic [3:0] digUMC,
    output logic [3:0] digDMC,
    output logic [3:0] digUHC,
    output logic [3:0] digDHC
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_REL} state_t;

    localparam logic [31:0] REF_LAST = 32'(REFRESH_DIV - 1);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT);

    state_t          state_q, state_d;
    logic [31:0]     ref_cnt_q, ref_cnt_d;
    logic [31:0]     wait_cnt_q, wait_cnt_d;
    logic [3:0]      idx_q, idx_d;
    logic            pend_q, pend_d;
    logic            sv_q, sv_d;
    logic            irq_q, vsync_q;
    logic            rtc_req_q, rtc_req_d;
    logic [7:0]      rtc_addr_q, rtc_addr_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic [8:0][7:0] shadow_q, shadow_d;
    logic [8:0][7:0] disp_q, disp_d;

    logic ref_wrap, irq_rise, commit;

    function automatic logic [7:0] reg_addr(input logic [3:0] i);
        case (i)
            4'd0:    reg_addr = 8'h21;
            4'd1:    reg_addr = 8'h22;
            4'd2:    reg_addr = 8'h23;
            4'd3:    reg_addr = 8'h24;
            4'd4:    reg_addr = 8'h25;
            4'd5:    reg_addr = 8'h26;
            4'd6:    reg_addr = 8'h41;
            4'd7:    reg_addr = 8'h42;
            4'd8:    reg_addr = 8'h43;
            default: reg_addr = 8'h00;
        endcase
    endfunction

    assign ref_wrap = (ref_cnt_q == REF_LAST);
    assign irq_rise = IRQ & ~irq_q;
    assign commit   = sv_q & vsync_q & ~vsync;

    always_comb begin
        state_d    = state_q;
        ref_cnt_d  = ref_wrap ? 32'd0 : ref_cnt_q + 32'd1;
        wait_cnt_d = wait_cnt_q;
        idx_d      = idx_q;
        pend_d     = pend_q;
        sv_d       = sv_q;
        rtc_req_d  = rtc_req_q;
        rtc_addr_d = rtc_addr_q;
        busy_d     = busy_q;
        err_d      = err_q;
        shadow_d   = shadow_q;
        disp_d     = disp_q;

        if (commit) begin
            disp_d = shadow_q;
            sv_d   = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // A full shadow bank blocks new sweeps until it has been displayed.
                if (pend_q && !sv_q) begin
                    pend_d  = 1'b0;
                    idx_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                rtc_addr_d = reg_addr(idx_q);
                rtc_req_d  = 1'b1;
                wait_cnt_d = 32'd0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (rtc_ack) begin
                    shadow_d[idx_q] = rtc_data;
                    rtc_req_d       = 1'b0;
                    state_d         = ST_REL;
                end else if (wait_cnt_q == TMO_LAST) begin
                    err_d     = 1'b1;
                    rtc_req_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            ST_REL: begin
                if (!rtc_ack) begin
                    if (idx_q == 4'd8) begin
                        sv_d    = 1'b1;
                        err_d   = 1'b0;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Set after the IDLE-exit clear so a trigger on that same edge is not lost.
        if (ref_wrap || irq_rise) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ref_cnt_q  <= 32'd0;
            wait_cnt_q <= 32'd0;
            idx_q      <= 4'd0;
            pend_q     <= 1'b0;
            sv_q       <= 1'b0;
            irq_q      <= 1'b0;
            vsync_q    <= 1'b0;
            rtc_req_q  <= 1'b0;
            rtc_addr_q <= 8'h00;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            shadow_q   <= '0;
            disp_q     <= '0;
        end else begin
            state_q    <= state_d;
            ref_cnt_q  <= ref_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            sv_q       <= sv_d;
            irq_q      <= IRQ;
            vsync_q    <= vsync;
            rtc_req_q  <= rtc_req_d;
            rtc_addr_q <= rtc_addr_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            shadow_q   <= shadow_d;
            disp_q     <= disp_d;
        end
    end

    assign rtc_req  = rtc_req_q;
    assign rtc_addr = rtc_addr_q;
    assign busy     = busy_q;
    assign err      = err_q;

    assign digDS  = disp_q[0][7:4];
    assign digUS  = disp_q[0][3:0];
    assign digDM  = disp_q[1][7:4];
    assign digUM  = disp_q[1][3:0];
    assign digDH  = disp_q[2][7:4];
    assign digUH  = disp_q[2][3:0];
    assign digDD  = disp_q[3][7:4];
    assign digUD  = disp_q[3][3:0];
    assign digDME = disp_q[4][7:4];
    assign digUME = disp_q[4][3:0];
    assign digDA  = disp_q[5][7:4];
    assign digUA  = disp_q[5][3:0];
    assign digDSC = disp_q[6][7:4];
    assign digUSC = disp_q[6][3:0];
    assign digDMC = disp_q[7][7:4];
    assign digUMC = disp_q[7][3:0];
    assign digDHC = disp_q[8][7:4];
    assign digUHC = disp_q[8][3:0];

endmodule

// File: tb/tb_rtc_read_ctrl.sv
// Bench for rtc_read_ctrl: a bus model with an address scoreboard, a commit
// scoreboard watching the digit outputs, and a second instance for periodic refresh.
module tb_rtc_read_ctrl;

    localparam int REF_DIV   = 300;
    localparam int TMO       = 20;
    localparam int REF_DIV_P = 50;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic [3:0] exp_d;
        logic [3:0] exp_u;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, irq, vsync, rtc_ack;
    logic [7:0]       rtc_data;
    logic             rtc_req, busy, err;
    logic [7:0]       rtc_addr;
    logic [17:0][3:0] dig;

    logic             reset_p, irq_p, vsync_p, ack_p;
    logic [7:0]       data_p;
    logic             req_p, busy_p, err_p;
    logic [7:0]       addr_p;
    logic [17:0][3:0] dig_p;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    vec_t             vecs [9];
    logic [7:0]       bus_mem [9];
    logic [8:0][7:0]  returned;
    logic [8:0][7:0]  ret_p;
    logic [7:0]       exp_addr_q [$];
    logic [71:0]      commit_q [$];
    logic [7:0]       no_ack_addr;
    int               ack_delay;
    bit               bus_en;
    bit               req_seen;
    int               wcnt, req_cycles, last_req_cycles;
    logic             err_at_drop;
    int               p_count;

    rtc_read_ctrl #(.REFRESH_DIV(REF_DIV), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .IRQ(irq), .vsync(vsync),
        .rtc_ack(rtc_ack), .rtc_data(rtc_data),
        .rtc_req(rtc_req), .rtc_addr(rtc_addr), .busy(busy), .err(err),
        .digUS(dig[0]), .digDS(dig[1]), .digUM(dig[2]), .digDM(dig[3]),
        .digUH(dig[4]), .digDH(dig[5]), .digUD(dig[6]), .digDD(dig[7]),
        .digUME(dig[8]), .digDME(dig[9]), .digUA(dig[10]), .digDA(dig[11]),
        .digUSC(dig[12]), .digDSC(dig[13]), .digUMC(dig[14]), .digDMC(dig[15]),
        .digUHC(dig[16]), .digDHC(dig[17])
    );

    rtc_read_ctrl #(.REFRESH_DIV(REF_DIV_P), .TIMEOUT(TMO)) dut_p (
        .clk(clk), .reset(reset_p), .IRQ(irq_p), .vsync(vsync_p),
        .rtc_ack(ack_p), .rtc_data(data_p),
        .rtc_req(req_p), .rtc_addr(addr_p), .busy(busy_p), .err(err_p),
        .digUS(dig_p[0]), .digDS(dig_p[1]), .digUM(dig_p[2]), .digDM(dig_p[3]),
        .digUH(dig_p[4]), .digDH(dig_p[5]), .digUD(dig_p[6]), .digDD(dig_p[7]),
        .digUME(dig_p[8]), .digDME(dig_p[9]), .digUA(dig_p[10]), .digDA(dig_p[11]),
        .digUSC(dig_p[12]), .digDSC(dig_p[13]), .digUMC(dig_p[14]), .digDMC(dig_p[15]),
        .digUHC(dig_p[16]), .digDHC(dig_p[17])
    );

    function automatic int addr_to_idx(input logic [7:0] a);
        case (a)
            8'h21: return 0;
            8'h22: return 1;
            8'h23: return 2;
            8'h24: return 3;
            8'h25: return 4;
            8'h26: return 5;
            8'h41: return 6;
            8'h42: return 7;
            8'h43: return 8;
            default: return 0;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [95:0] act, input logic [95:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [95:0] act);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got 0x%0h, expected nothing", name, act);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bus model: checks each new request address against the scoreboard and acks after ack_delay.
    initial begin
        forever begin
            @(negedge clk);
            if (bus_en) begin
                if (rtc_req) begin
                    if (!req_seen) begin
                        req_seen   = 1'b1;
                        wcnt       = 0;
                        req_cycles = 0;
                        if (exp_addr_q.size() == 0) fail_now("unexpected_request", 96'(rtc_addr));
                        else check_output("req_addr", 96'(rtc_addr), 96'(exp_addr_q.pop_front()));
                    end
                    req_cycles++;
                    if (!rtc_ack && rtc_addr != no_ack_addr) begin
                        wcnt++;
                        if (wcnt >= ack_delay) begin
                            rtc_ack = 1'b1;
                            rtc_data = bus_mem[addr_to_idx(rtc_addr)];
                            returned[addr_to_idx(rtc_addr)] = rtc_data;
                        end
                    end
                end else begin
                    if (req_seen) begin
                        last_req_cycles = req_cycles;
                        err_at_drop     = err;
                    end
                    req_seen = 1'b0;
                    rtc_ack  = 1'b0;
                end
            end
        end
    end

    // Any change of the digit outputs must match the next expected commit.
    initial begin
        logic [71:0] prev;
        logic [71:0] expv;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev = '0;
            end else if (72'(dig) !== prev) begin
                if (commit_q.size() == 0) begin
                    check_output("unexpected_output_change", 96'(dig), 96'(prev));
                end else begin
                    expv = commit_q.pop_front();
                    check_output("commit_value", 96'(dig), 96'(expv));
                end
                prev = 72'(dig);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (req_p && !ack_p) begin
                ack_p  = 1'b1;
                data_p = 8'(p_count);
                ret_p[addr_to_idx(addr_p)] = data_p;
                p_count++;
            end else if (!req_p) begin
                ack_p = 1'b0;
            end
        end
    end

    task automatic wait_busy(input bit use_p, input logic lvl, input int max_cyc, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((use_p ? busy_p : busy) !== lvl && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if ((use_p ? busy_p : busy) !== lvl) check_output(name, 96'(use_p ? busy_p : busy), 96'(lvl));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        irq   = 1'b0;
        vsync = 1'b1;
        exp_addr_q.delete();
        commit_q.delete();
        no_ack_addr = 8'hFF;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic load_mem(input logic [7:0] mask);
        for (int i = 0; i < 9; i++) bus_mem[i] = vecs[i].data ^ mask;
    endtask

    task automatic push_addrs(input int n);
        for (int i = 0; i < n; i++) exp_addr_q.push_back(vecs[i].addr);
    endtask

    task automatic apply_irq();
        @(negedge clk);
        irq = 1'b1;
        @(negedge clk);
        irq = 1'b0;
    endtask

    task automatic do_commit(input bit expect_update);
        if (expect_update) commit_q.push_back(72'(returned));
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        check_output("commit_pending", 96'(commit_q.size()), 96'(0));
    endtask

    initial begin
        logic [71:0] snap;
        int n, t0, start, prev_start;
        bit found;

        vecs[0] = '{8'h21, 8'h59, 4'd5, 4'd9};
        vecs[1] = '{8'h22, 8'h34, 4'd3, 4'd4};
        vecs[2] = '{8'h23, 8'h12, 4'd1, 4'd2};
        vecs[3] = '{8'h24, 8'h31, 4'd3, 4'd1};
        vecs[4] = '{8'h25, 8'h12, 4'd1, 4'd2};
        vecs[5] = '{8'h26, 8'h16, 4'd1, 4'd6};
        vecs[6] = '{8'h41, 8'h05, 4'd0, 4'd5};
        vecs[7] = '{8'h42, 8'h10, 4'd1, 4'd0};
        vecs[8] = '{8'h43, 8'h01, 4'd0, 4'd1};

        reset = 1'b0; irq = 1'b0; vsync = 1'b1; rtc_ack = 1'b0; rtc_data = 8'h00;
        reset_p = 1'b0; irq_p = 1'b0; vsync_p = 1'b1; ack_p = 1'b0; data_p = 8'h00;
        bus_en = 1'b0; req_seen = 1'b0; ack_delay = 2; no_ack_addr = 8'hFF;
        err_at_drop = 1'b0; last_req_cycles = 0; p_count = 0;
        returned = '0; ret_p = '0;

        $display("[TB] reset with random inputs");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            irq      = 1'($urandom);
            vsync    = 1'($urandom);
            rtc_ack  = 1'($urandom);
            rtc_data = 8'($urandom);
            #1;
            check_output("reset_outputs", 96'({rtc_req, rtc_addr, busy, err, dig}), 96'(0));
        end
        @(negedge clk);
        irq = 1'b0; vsync = 1'b1; rtc_ack = 1'b0;
        bus_en = 1'b1;
        reset  = 1'b1;
        repeat (20) @(negedge clk);
        check_output("idle_after_reset", 96'({busy, rtc_req}), 96'(0));

        $display("[TB] IRQ sweep");
        load_mem(8'h00);
        push_addrs(9);
        @(negedge clk);
        irq = 1'b1;
        @(negedge clk);
        irq = 1'b0;
        check_output("lat_edge1", 96'({busy, rtc_req}), 96'(2'b00));
        @(negedge clk);
        check_output("lat_edge2", 96'({busy, rtc_req}), 96'(2'b10));
        @(negedge clk);
        check_output("lat_edge3", 96'({rtc_req, rtc_addr}), 96'({1'b1, 8'h21}));
        wait_busy(1'b0, 1'b0, 200, "sweep_done_b");
        check_output("no_early_update", 96'(dig), 96'(0));
        check_output("err_clear_b", 96'(err), 96'(0));
        repeat (5) @(negedge clk);
        do_commit(1'b1);
        for (int i = 0; i < 9; i++)
            check_output($sformatf("digits_%0h", vecs[i].addr),
                         96'({dig[2*i+1], dig[2*i]}), 96'({vecs[i].exp_d, vecs[i].exp_u}));

        $display("[TB] trigger merge");
        do_reset();
        load_mem(8'h00);
        push_addrs(9);
        push_addrs(9);
        repeat (REF_DIV - 1) @(posedge clk);
        @(negedge clk);
        irq = 1'b1;
        @(negedge clk);
        irq = 1'b0;
        wait_busy(1'b0, 1'b1, 5, "merge_start1");
        repeat (10) @(negedge clk);
        apply_irq();
        wait_busy(1'b0, 1'b0, 200, "merge_done1");
        load_mem(8'h11);
        repeat (15) @(negedge clk);
        check_output("hold_until_commit", 96'({busy, rtc_req}), 96'(0));
        do_commit(1'b1);
        wait_busy(1'b0, 1'b1, 5, "merge_start2");
        wait_busy(1'b0, 1'b0, 200, "merge_done2");
        do_commit(1'b1);
        repeat (20) @(negedge clk);
        check_output("merge_two_sweeps", 96'({exp_addr_q.size(), busy}), 96'(0));

        $display("[TB] timeout");
        do_reset();
        load_mem(8'h00);
        push_addrs(9);
        apply_irq();
        wait_busy(1'b0, 1'b1, 5, "good_start");
        wait_busy(1'b0, 1'b0, 200, "good_done");
        do_commit(1'b1);
        snap = 72'(dig);
        no_ack_addr = 8'h23;
        push_addrs(3);
        apply_irq();
        wait_busy(1'b0, 1'b1, 5, "tmo_start");
        wait_busy(1'b0, 1'b0, 200, "tmo_done");
        check_output("tmo_req_cycles", 96'(last_req_cycles), 96'(TMO + 1));
        check_output("tmo_err_at_drop", 96'(err_at_drop), 96'(1));
        check_output("tmo_err", 96'({err, rtc_req}), 96'(2'b10));
        do_commit(1'b0);
        check_output("tmo_keeps_outputs", 96'(dig), 96'(snap));
        no_ack_addr = 8'hFF;
        load_mem(8'h22);
        push_addrs(9);
        apply_irq();
        wait_busy(1'b0, 1'b1, 5, "recover_start");
        wait_busy(1'b0, 1'b0, 200, "recover_done");
        check_output("err_cleared", 96'(err), 96'(0));
        do_commit(1'b1);
        check_output("recover_seconds", 96'({dig[1], dig[0]}), 96'(8'h59 ^ 8'h22));

        $display("[TB] reset mid-sweep");
        do_reset();
        load_mem(8'h00);
        push_addrs(5);
        apply_irq();
        n = 0;
        found = 1'b0;
        while (!found && n < 80) begin
            @(negedge clk);
            if (rtc_req && rtc_addr == 8'h25) found = 1'b1;
            n++;
        end
        if (!found) fail_now("wait_idx4_timeout", 96'(rtc_addr));
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_output("async_req_drop", 96'({rtc_req, busy}), 96'(0));
        repeat (3) @(negedge clk);
        check_output("mid_reset_digits", 96'(dig), 96'(0));
        reset = 1'b1;
        repeat (10) @(negedge clk);
        do_commit(1'b0);
        check_output("no_commit_after_reset", 96'({dig, busy, rtc_req}), 96'(0));
        check_output("mid_reset_scoreboard", 96'(exp_addr_q.size()), 96'(0));

        $display("[TB] periodic refresh");
        @(negedge clk);
        reset_p = 1'b1;
        t0 = cyc;
        prev_start = 0;
        for (int s = 0; s < 3; s++) begin
            wait_busy(1'b1, 1'b1, 120, "periodic_start");
            start = cyc - t0;
            if (s == 0) check_output("periodic_first", 96'(start), 96'(REF_DIV_P + 1));
            else        check_output("periodic_spacing", 96'(start - prev_start), 96'(REF_DIV_P));
            prev_start = start;
            wait_busy(1'b1, 1'b0, 100, "periodic_done");
            snap = 72'(ret_p);
            @(negedge clk);
            vsync_p = 1'b0;
            @(negedge clk);
            vsync_p = 1'b1;
            @(negedge clk);
            check_output("periodic_commit", 96'(dig_p), 96'(snap));
        end
        check_output("periodic_err", 96'(err_p), 96'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
